fpu_divide_iterative: RTL and testbench

//  Sequential restoring mantissa divider for the FPU divide path. Successor to the single-cycle divide

---
 rtl/fpu_divide_iterative_pkg.sv | 25 ++
 rtl/fpu_divide_step.sv | 34 +++
 rtl/fpu_divide_iterative.sv | 146 ++++++++++++++
 tb/tb_fpu_divide_iterative.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_divide_iterative_pkg.sv
// Shared types and helpers for the iterative FPU mantissa divider.
package fpu_divide_iterative_pkg;

   localparam int FPU_MANT_WIDTH = 24;
   localparam int FPU_EXTRA_BITS = 27;
   localparam int FPU_QUOT_WIDTH = FPU_MANT_WIDTH + FPU_EXTRA_BITS;

   typedef enum logic [1:0] {
      FPU_DIVIDE_IDLE,
      FPU_DIVIDE_BUSY,
      FPU_DIVIDE_DONE
   } fpu_divide_state_t;

   typedef struct packed {
      logic [FPU_QUOT_WIDTH-1:0] quotient;
      logic                      sticky;
      logic                      div_zero;
   } fpu_divide_result_t;

   // Register width able to hold 0..n-1, never narrower than one bit.
   function automatic int fpu_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpu_divide_step.sv
// Combinational slice of BITS_PER_CYCLE chained restoring divide steps.
module fpu_divide_step
   import fpu_divide_iterative_pkg::*;
#(
   parameter int MANT_WIDTH = 24,
   parameter int QUOT_WIDTH = 51,
   parameter int BPC        = 1,
   parameter int IDX_W      = 6,
   parameter int REM_W      = QUOT_WIDTH + MANT_WIDTH
)(
   input  logic [REM_W-1:0]      i_rem,
   input  logic [MANT_WIDTH-1:0] i_b,
   input  logic [IDX_W-1:0]      i_bit_idx,
   output logic [REM_W-1:0]      o_rem,
   output logic [BPC-1:0]        o_q
);

   logic [REM_W-1:0] w_rem [0:BPC];

   assign w_rem[0] = i_rem;

   // Stage g resolves quotient bit i_bit_idx + BPC-1-g, MSB first.
   for (genvar g = 0; g < BPC; g++) begin : g_stage
      logic [REM_W-1:0] w_x;
      logic             w_fit;
      assign w_x = REM_W'(i_b) << (32'(i_bit_idx) + 32'(BPC - 1 - g));
      assign w_fit = (w_x <= w_rem[g]);
      assign w_rem[g+1] = w_fit ? (w_rem[g] - w_x) : w_rem[g];
      assign o_q[BPC-1-g] = w_fit;
   end

   assign o_rem = w_rem[BPC];

endmodule

// File: rtl/fpu_divide_iterative.sv
// Sequential restoring mantissa divider: floor((a << EXTRA_BITS) / b)
// with valid/ready handshake, sticky, divide-by-zero and tag passthrough.
module fpu_divide_iterative
   import fpu_divide_iterative_pkg::*;
#(
   parameter  int MANT_WIDTH     = 24,
   parameter  int EXTRA_BITS     = 27,
   parameter  int BITS_PER_CYCLE = 1,
   parameter  int TAG_WIDTH      = 8,
   localparam int QUOT_WIDTH     = MANT_WIDTH + EXTRA_BITS
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MANT_WIDTH-1:0] in_a,
   input  logic [MANT_WIDTH-1:0] in_b,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOT_WIDTH-1:0] out_quotient,
   output logic                  out_sticky,
   output logic                  out_div_zero,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   localparam int ITER  = QUOT_WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = fpu_width(ITER);
   localparam int IDX_W = fpu_width(QUOT_WIDTH);
   localparam int REM_W = QUOT_WIDTH + MANT_WIDTH;

   if (QUOT_WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
      $error("QUOT_WIDTH must be a multiple of BITS_PER_CYCLE");
   end

   fpu_divide_state_t r_state;
   fpu_divide_state_t w_next;

   logic [CNT_W-1:0]          r_cnt;
   logic [REM_W-1:0]          r_rem;
   logic [MANT_WIDTH-1:0]     r_b;
   logic [QUOT_WIDTH-1:0]     r_q;
   logic [TAG_WIDTH-1:0]      r_tag;
   logic [QUOT_WIDTH-1:0]     r_out_q;
   logic                      r_out_sticky;
   logic                      r_out_dz;
   logic [TAG_WIDTH-1:0]      r_out_tag;

   logic                      w_accept;
   logic                      w_b_zero;
   logic                      w_last;
   logic [IDX_W-1:0]          w_bit_idx;
   logic [REM_W-1:0]          w_rem_next;
   logic [BITS_PER_CYCLE-1:0] w_q_slice;
   logic [QUOT_WIDTH-1:0]     w_q_next;

   assign w_accept  = in_valid && (r_state == FPU_DIVIDE_IDLE);
   assign w_b_zero  = (in_b == '0);
   assign w_last    = (r_cnt == '0);
   assign w_bit_idx = IDX_W'(32'(r_cnt) * BITS_PER_CYCLE);

   fpu_divide_step #(
      .MANT_WIDTH (MANT_WIDTH),
      .QUOT_WIDTH (QUOT_WIDTH),
      .BPC        (BITS_PER_CYCLE),
      .IDX_W      (IDX_W),
      .REM_W      (REM_W)
   ) u_step (
      .i_rem     (r_rem),
      .i_b       (r_b),
      .i_bit_idx (w_bit_idx),
      .o_rem     (w_rem_next),
      .o_q       (w_q_slice)
   );

   // Quotient bits arrive MSB first, so shift them in from the bottom.
   if (BITS_PER_CYCLE == QUOT_WIDTH) begin : g_q_full
      assign w_q_next = w_q_slice;
   end else begin : g_q_shift
      assign w_q_next = {r_q[QUOT_WIDTH-BITS_PER_CYCLE-1:0], w_q_slice};
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         FPU_DIVIDE_IDLE:
            if (w_accept)
               w_next = w_b_zero ? FPU_DIVIDE_DONE : FPU_DIVIDE_BUSY;
         FPU_DIVIDE_BUSY:
            if (w_last) w_next = FPU_DIVIDE_DONE;
         FPU_DIVIDE_DONE:
            if (out_ready) w_next = FPU_DIVIDE_IDLE;
         default:
            w_next = FPU_DIVIDE_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= FPU_DIVIDE_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_rem        <= '0;
         r_b          <= '0;
         r_q          <= '0;
         r_tag        <= '0;
         r_out_q      <= '0;
         r_out_sticky <= 1'b0;
         r_out_dz     <= 1'b0;
         r_out_tag    <= '0;
      end else if (w_accept) begin
         r_rem <= REM_W'({in_a, {EXTRA_BITS{1'b0}}});
         r_b   <= in_b;
         r_tag <= in_tag;
         r_q   <= '0;
         r_cnt <= CNT_W'(ITER - 1);
         if (w_b_zero) begin
            r_out_q      <= '1;
            r_out_sticky <= 1'b0;
            r_out_dz     <= 1'b1;
            r_out_tag    <= in_tag;
         end
      end else if (r_state == FPU_DIVIDE_BUSY) begin
         r_rem <= w_rem_next;
         r_q   <= w_q_next;
         r_cnt <= r_cnt - CNT_W'(1);
         if (w_last) begin
            r_out_q      <= w_q_next;
            r_out_sticky <= (w_rem_next != '0);
            r_out_dz     <= 1'b0;
            r_out_tag    <= r_tag;
         end
      end
   end

   assign in_ready     = (r_state == FPU_DIVIDE_IDLE);
   assign out_valid    = (r_state == FPU_DIVIDE_DONE);
   assign out_quotient = r_out_q;
   assign out_sticky   = r_out_sticky;
   assign out_div_zero = r_out_dz;
   assign out_tag      = r_out_tag;

endmodule

// File: tb/tb_fpu_divide_iterative.sv
// Directed and randomised checks of the iterative mantissa divider.
module tb_fpu_divide_iterative;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_a = '0;
   logic [23:0] in_b = '0;
   logic [7:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [50:0] out_quotient;
   logic        out_sticky;
   logic        out_div_zero;
   logic [7:0]  out_tag;

   logic        in_valid3 = 1'b0;
   logic        in_ready3;
   logic [23:0] in_a3 = '0;
   logic [23:0] in_b3 = '0;
   logic [7:0]  in_tag3 = '0;
   logic        out_valid3;
   logic        out_ready3 = 1'b0;
   logic [50:0] out_quotient3;
   logic        out_sticky3;
   logic        out_div_zero3;
   logic [7:0]  out_tag3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fpu_divide_iterative dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quotient(out_quotient), .out_sticky(out_sticky),
      .out_div_zero(out_div_zero), .out_tag(out_tag)
   );

   fpu_divide_iterative #(.BITS_PER_CYCLE(3)) dut3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid3), .in_ready(in_ready3),
      .in_a(in_a3), .in_b(in_b3), .in_tag(in_tag3),
      .out_valid(out_valid3), .out_ready(out_ready3),
      .out_quotient(out_quotient3), .out_sticky(out_sticky3),
      .out_div_zero(out_div_zero3), .out_tag(out_tag3)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Offer one operation and wait for out_valid; lat counts cycles after accept.
   task automatic op(input logic [23:0] a, input logic [23:0] b,
                     input logic [7:0] tag, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 24'hFFFFFF;
      in_b     = 24'h000001;
      in_tag   = 8'hEE;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic op3(input logic [23:0] a, input logic [23:0] b,
                      input logic [7:0] tag, output int lat);
      in_valid3 = 1'b1;
      in_a3     = a;
      in_b3     = b;
      in_tag3   = tag;
      @(negedge clk);
      in_valid3 = 1'b0;
      in_a3     = 24'hFFFFFF;
      in_b3     = 24'h000001;
      lat = 1;
      while (!out_valid3 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests += 7;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      if (out_quotient !== 51'h0) begin
         n_fail++; $display("FAIL reset_quotient: got %h want 0", out_quotient);
      end
      if (out_sticky !== 1'b0) begin
         n_fail++; $display("FAIL reset_sticky: got %b want 0", out_sticky);
      end
      if (out_div_zero !== 1'b0) begin
         n_fail++; $display("FAIL reset_div_zero: got %b want 0", out_div_zero);
      end
      if (out_tag !== 8'h00) begin
         n_fail++; $display("FAIL reset_tag: got %h want 00", out_tag);
      end
      if (in_ready3 !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready3: got %b want 1", in_ready3);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [23:0] a_v [3] = '{24'h800000, 24'hC00000, 24'h800000};
      logic [23:0] b_v [3] = '{24'h800000, 24'h800000, 24'hC00000};
      logic [50:0] q_v [3] = '{51'h8000000, 51'hC000000, 51'h5555555};
      logic        s_v [3] = '{1'b0, 1'b0, 1'b1};
      int lat;
      for (int i = 0; i < 3; i++) begin
         op(a_v[i], b_v[i], 8'(8'h10 + i), lat);
         n_tests += 5;
         if (lat !== 52) begin
            n_fail++; $display("FAIL basic%0d_latency: got %0d want 52", i, lat);
         end
         if (out_quotient !== q_v[i]) begin
            n_fail++;
            $display("FAIL basic%0d_quotient: got %h want %h", i, out_quotient, q_v[i]);
         end
         if (out_sticky !== s_v[i]) begin
            n_fail++;
            $display("FAIL basic%0d_sticky: got %b want %b", i, out_sticky, s_v[i]);
         end
         if (out_div_zero !== 1'b0) begin
            n_fail++; $display("FAIL basic%0d_div_zero: got %b want 0", i, out_div_zero);
         end
         if (out_tag !== 8'(8'h10 + i)) begin
            n_fail++; $display("FAIL basic%0d_tag: got %h want %h", i, out_tag, 8'(8'h10 + i));
         end
         drain();
      end
   endtask

   task automatic test_bpc3();
      int lat;
      op3(24'h800000, 24'hC00000, 8'h33, lat);
      n_tests += 4;
      if (lat !== 18) begin
         n_fail++; $display("FAIL bpc3_latency: got %0d want 18", lat);
      end
      if (out_quotient3 !== 51'h5555555) begin
         n_fail++; $display("FAIL bpc3_quotient: got %h want 5555555", out_quotient3);
      end
      if (out_sticky3 !== 1'b1) begin
         n_fail++; $display("FAIL bpc3_sticky: got %b want 1", out_sticky3);
      end
      if (out_tag3 !== 8'h33) begin
         n_fail++; $display("FAIL bpc3_tag: got %h want 33", out_tag3);
      end
      out_ready3 = 1'b1;
      @(negedge clk);
      out_ready3 = 1'b0;
   endtask

   task automatic test_div_zero();
      int lat;
      op(24'h9A0000, 24'h000000, 8'hC3, lat);
      n_tests += 5;
      if (lat !== 1) begin
         n_fail++; $display("FAIL dz_latency: got %0d want 1", lat);
      end
      if (out_quotient !== 51'h7FFFFFFFFFFFF) begin
         n_fail++; $display("FAIL dz_quotient: got %h want 7ffffffffffff", out_quotient);
      end
      if (out_div_zero !== 1'b1) begin
         n_fail++; $display("FAIL dz_flag: got %b want 1", out_div_zero);
      end
      if (out_sticky !== 1'b0) begin
         n_fail++; $display("FAIL dz_sticky: got %b want 0", out_sticky);
      end
      if (out_tag !== 8'hC3) begin
         n_fail++; $display("FAIL dz_tag: got %h want c3", out_tag);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      op(24'h800000, 24'hC00000, 8'h5A, lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_a     = 24'hABCDEF;
         in_b     = 24'h000000;
         in_tag   = 8'hFF;
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             out_quotient !== 51'h5555555 || out_sticky !== 1'b1 ||
             out_div_zero !== 1'b0 || out_tag !== 8'h5A)
            bad++;
      end
      in_valid = 1'b0;
      n_tests += 3;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL bp_stable: got %0d unstable cycles want 0 (q=%h tag=%h)",
                  bad, out_quotient, out_tag);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid);
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      in_valid = 1'b1;
      in_a     = 24'h800000;
      in_b     = 24'hC00000;
      in_tag   = 8'h77;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests += 5;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_in_ready: got %b want 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL abort_out_valid: got %b want 0", out_valid);
      end
      if (out_quotient !== 51'h0) begin
         n_fail++; $display("FAIL abort_quotient: got %h want 0", out_quotient);
      end
      op(24'hC00000, 24'h800000, 8'h78, lat);
      if (out_quotient !== 51'hC000000) begin
         n_fail++; $display("FAIL abort_next_quotient: got %h want c000000", out_quotient);
      end
      if (lat !== 52) begin
         n_fail++; $display("FAIL abort_next_latency: got %0d want 52", lat);
      end
      drain();
   endtask

   task automatic test_random();
      logic [23:0] a, b;
      logic [50:0] num, q_exp;
      logic        s_exp;
      int lat;
      for (int i = 0; i < 24; i++) begin
         a = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
         b = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
         num   = {a, 27'b0};
         q_exp = num / 51'(b);
         s_exp = (num % 51'(b)) != 0;
         op(a, b, 8'(i), lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         n_tests += 3;
         if (out_quotient !== q_exp) begin
            n_fail++;
            $display("FAIL rand%0d_quotient: a=%h b=%h got %h want %h",
                     i, a, b, out_quotient, q_exp);
         end
         if (out_sticky !== s_exp) begin
            n_fail++;
            $display("FAIL rand%0d_sticky: a=%h b=%h got %b want %b",
                     i, a, b, out_sticky, s_exp);
         end
         if (out_tag !== 8'(i)) begin
            n_fail++; $display("FAIL rand%0d_tag: got %h want %h", i, out_tag, 8'(i));
         end
         drain();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bpc3();
      test_div_zero();
      test_backpressure();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
